alu_div_iter: RTL
=================

ALU_DIV_ITER -- requirements
Module: alu_div_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand and result width in bits.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port Rst, input, 1, a synchronous, active-low reset sampled on the rising edge of Clk.
REQ-004 The block SHALL have port Start, input, 1, a request to begin a divide; sampled only in IDLE.
REQ-005 The block SHALL have port Signed, input, 1: 1 selects two's-complement (DIV), 0 selects unsigned (DIVU); sampled with Start.
REQ-006 The block SHALL have port A, input, WIDTH, the dividend; sampled with Start.
REQ-007 The block SHALL have port B, input, WIDTH, the divisor; sampled with Start.
REQ-008 The block SHALL have port Busy, output, 1, high while an operation is in progress.
REQ-009 The block SHALL have port Done, output, 1, a one-cycle pulse marking valid results.
REQ-010 The block SHALL have port Quotient, output, WIDTH, the LO result.
REQ-011 The block SHALL have port Remainder, output, WIDTH, the HI result.
REQ-012 The block SHALL have port DivByZero, output, 1, set when the captured B was zero.

Function
REQ-013 The block SHALL implement a state machine with states IDLE -> CALC -> FIX -> IDLE.
REQ-014 In IDLE with Start=1, the block SHALL capture A, B and Signed, load the magnitudes |A| and |B| (raw values when Signed=0), clear the partial remainder and iteration counter, and enter CALC.
REQ-015 CALC SHALL perform one restoring-division step per cycle (shift remainder:dividend left by 1, trial-subtract the divisor magnitude, keep the result and set the quotient bit when it is non-negative); after exactly WIDTH steps it SHALL enter FIX.
REQ-016 FIX SHALL apply signs: the quotient is negated when Signed=1 and the signs of A and B differ; the remainder is negated when Signed=1 and A is negative; results are registered to Quotient/Remainder and the machine returns to IDLE.
REQ-017 Latency SHALL be fixed at WIDTH+2 clock edges for all operands: Done SHALL be high for exactly the one cycle following the edge WIDTH+2 after the edge that sampled Start (34 for WIDTH=32).
REQ-018 Busy SHALL be high from the cycle after the edge that samples Start until the cycle in which Done is high, inclusive, and low otherwise.
REQ-019 Start while Busy=1 SHALL be ignored; a Start sampled in the cycle Done is high (IDLE) SHALL be accepted, giving back-to-back operation.
REQ-020 Quotient, Remainder and DivByZero SHALL hold their values from the last completed operation until the next FIX state; they SHALL NOT change during CALC.
REQ-021 B=0 SHALL run the full latency and yield Quotient=all-ones, Remainder=A (as captured, unsigned or signed alike), DivByZero=1; otherwise DivByZero=0.
REQ-022 Signed overflow (A=most-negative, B=-1) SHALL yield Quotient=most-negative (0x80000000), Remainder=0, DivByZero=0.
REQ-023 Magnitude of the most-negative value SHALL be computed in WIDTH bits unsigned (0x80000000) without loss.

Reset
REQ-024 When Rst=0 at a rising edge, the block SHALL enter IDLE and set Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0, and clear all internal registers, regardless of state.
REQ-025 Reset in mid-operation SHALL abandon the operation with no Done pulse; Start is ignored while Rst=0.

Verification
REQ-026 Unsigned: Signed=0, A=100, B=7, Start 1 cycle -> Done pulse 34 edges later, Quotient=14, Remainder=2, DivByZero=0.
REQ-027 Signed: Signed=1, A=0xFFFFFFF9 (-7), B=2 -> Quotient=0xFFFFFFFD (-3), Remainder=0xFFFFFFFF (-1); and Signed=0 on same operands -> Quotient=0x7FFFFFFC, Remainder=1.
REQ-028 Divide by zero: A=0x12345678, B=0, Signed=1 -> Quotient=0xFFFFFFFF, Remainder=0x12345678, DivByZero=1, same 34-edge latency.
REQ-029 Overflow: Signed=1, A=0x80000000, B=0xFFFFFFFF -> Quotient=0x80000000, Remainder=0.
REQ-030 Handshake: Start held high throughout a divide -> no restart while Busy; a second op accepted in the Done cycle completes 34 edges later with Busy continuous; Start pulses mid-CALC produce no extra Done.
REQ-031 Reset: Rst=0 at cycle 10 of a divide -> next cycle Busy=0, Done=0, all results 0, no Done pulse thereafter until a new Start.

Source files
------------

// File: rtl/alu_div_iter.sv
// Iterative restoring divider (DIV/DIVU): one quotient bit per cycle, fixed WIDTH+2 latency.
// Results and DivByZero are registered and only update when an operation completes.
module alu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] a_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             bzero_q;
    logic             fix_ph_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted_d;
    logic [WIDTH+1:0] trial_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;

    // One restoring step and operand magnitudes; the most-negative value maps to itself unsigned.
    always_comb begin
        shifted_d = {rem_q, quo_q[WIDTH-1]};
        trial_d   = {1'b0, shifted_d} - {2'b00, div_q};
        if (!trial_d[WIDTH+1]) begin
            rem_d = trial_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shifted_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (Signed && A[WIDTH-1]) begin
            a_mag_d = -A;
        end else begin
            a_mag_d = A;
        end
        if (Signed && B[WIDTH-1]) begin
            b_mag_d = -B;
        end else begin
            b_mag_d = B;
        end
    end

    // Control FSM and all registered state; FIX takes two cycles (sign fix, then publish).
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            div_q       <= {WIDTH{1'b0}};
            a_q         <= {WIDTH{1'b0}};
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            bzero_q     <= 1'b0;
            fix_ph_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        a_q      <= A;
                        quo_q    <= a_mag_d;
                        div_q    <= b_mag_d;
                        rem_q    <= {WIDTH{1'b0}};
                        cnt_q    <= {CNT_W{1'b0}};
                        q_neg_q  <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_q  <= Signed & A[WIDTH-1];
                        bzero_q  <= (B == {WIDTH{1'b0}});
                        fix_ph_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end else begin
                        state_q <= S_CALC;
                    end
                end
                S_FIX: begin
                    if (!fix_ph_q) begin
                        if (q_neg_q) begin
                            quo_q <= -quo_q;
                        end else begin
                            quo_q <= quo_q;
                        end
                        if (r_neg_q) begin
                            rem_q <= -rem_q;
                        end else begin
                            rem_q <= rem_q;
                        end
                        fix_ph_q <= 1'b1;
                    end else begin
                        // Divide by zero reports all-ones and the raw dividend regardless of sign.
                        if (bzero_q) begin
                            quotient_q  <= {WIDTH{1'b1}};
                            remainder_q <= a_q;
                        end else begin
                            quotient_q  <= quo_q;
                            remainder_q <= rem_q;
                        end
                        dbz_q    <= bzero_q;
                        done_q   <= 1'b1;
                        fix_ph_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quotient_q;
    assign Remainder = remainder_q;
    assign DivByZero = dbz_q;

endmodule
